// File: rtl/bk_adder_latch_top.sv
// rtl/bk_adder_latch_top.sv - Brent-Kung adder / latch-bank wrapper; BK_SUM_REG_EN registers the sum
module bk_adder_latch_top #(
    parameter int WIDTH  = 6,
    parameter int NLATCH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Prefix positions: 0 carries cin as g_-1, position k+1 carries operand bit k.
    localparam int NPOS = WIDTH + 1;
    localparam int LVLS = $clog2(NPOS);

    logic             mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic [WIDTH-1:0] prop;
    logic [1:0]       gp [NPOS];
    logic [WIDTH:0]   sum_comb;
    logic [WIDTH:0]   adder_out;
    logic [NLATCH-1:0] q;
    logic             unused_bits;

    assign mode = ui_in[6];
    assign op_a = ui_in[WIDTH-1:0];
    assign op_b = uio_in[WIDTH-1:0];
    assign cin  = uio_in[7];

    // Prefix cell on packed {G,P}: hi is the more significant group.
    function automatic logic [1:0] prefix_op(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction

    always_comb begin
        for (int i = 0; i < NPOS; i++) begin
            gp[i] = 2'b00;
        end
        prop = op_a ^ op_b;
        gp[0] = {cin, 1'b0};
        for (int k = 0; k < WIDTH; k++) begin
            gp[k+1] = {op_a[k] & op_b[k], prop[k]};
        end

        // Up-sweep: nodes whose index+1 is a multiple of 2*span absorb the group below.
        for (int l = 0; l < LVLS; l++) begin
            for (int i = 0; i < NPOS; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    gp[i] = prefix_op(gp[i], gp[i - (1 << l)]);
                end
            end
        end

        // Down-sweep: fill the odd-multiple positions from completed prefixes.
        for (int l = LVLS - 1; l >= 0; l--) begin
            for (int i = 0; i < NPOS; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) >= (3 << l))) begin
                    gp[i] = prefix_op(gp[i], gp[i - (1 << l)]);
                end
            end
        end

        // gp[k][1] is now the carry into operand bit k.
        for (int k = 0; k < WIDTH; k++) begin
            sum_comb[k] = prop[k] ^ gp[k][1];
        end
        sum_comb[WIDTH] = gp[WIDTH][1];
    end

`ifdef BK_SUM_REG_EN
    logic [WIDTH:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_comb;
        end
    end

    assign adder_out = sum_q;
`else
    assign adder_out = sum_comb;
`endif

    // Each channel writes only when the bank is selected and its own enable is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (mode) begin
            for (int i = 0; i < NLATCH; i++) begin
                if (uio_in[i]) begin
                    q[i] <= ui_in[i];
                end
            end
        end
    end

    assign uo_out      = mode ? 8'(q) : 8'(adder_out);
    assign uio_out     = 8'h00;
    assign uio_oe      = 8'h00;
    assign unused_bits = ^{ena, ui_in[7], uio_in[6]};

endmodule

// File: tb/tb_bk_adder_latch_top.sv
// tb/tb_bk_adder_latch_top.sv - self-checking bench for bk_adder_latch_top
module tb_bk_adder_latch_top;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    logic [3:0] mq;
    logic [7:0] msum_q;
    logic       model_ok = 1'b0;

    bk_adder_latch_top dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_sum(input logic [7:0] ui, input logic [7:0] uio);
        int s;
        s = int'(ui[5:0]) + int'(uio[5:0]) + int'(uio[7]);
        return 8'(s);
    endfunction

    // Reference: latches and (optionally) the registered sum, from the plain rules.
    always @(posedge clk) begin
        if (rst) begin
            mq       <= 4'h0;
            msum_q   <= 8'h00;
            model_ok <= 1'b1;
        end else begin
            msum_q <= model_sum(ui_in, uio_in);
            if (ui_in[6]) begin
                for (int i = 0; i < 4; i++) begin
                    if (uio_in[i]) mq[i] <= ui_in[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp;
        if (model_ok) begin
`ifdef BK_SUM_REG_EN
            exp = ui_in[6] ? {4'h0, mq} : msum_q;
`else
            exp = ui_in[6] ? {4'h0, mq} : model_sum(ui_in, uio_in);
`endif
            check("cycle_uo_out", uo_out, exp);
            check("cycle_uio_out", uio_out, 8'h00);
            check("cycle_uio_oe", uio_oe, 8'h00);
        end
    end

    task automatic apply(input logic [7:0] ui, input logic [7:0] uio, input logic r);
        ui_in  = ui;
        uio_in = uio;
        rst    = r;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] bitv;
        logic [7:0] qb;
        ena = 1'b0;
        apply(8'h40, 8'h00, 1'b1);
        tick();
        apply(8'h40, 8'h00, 1'b0);
        tick();
        check("reset_state", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);

        ena = 1'b1;
        apply(8'd2, 8'd5, 1'b0);    tick(); check("add_2_5", uo_out, 8'h07);
        apply(8'd2, 8'd133, 1'b0);  tick(); check("add_cin", uo_out, 8'h08);
        apply(8'd63, 8'd191, 1'b0); tick(); check("add_max_cin", uo_out, 8'h7F);
        apply(8'd63, 8'd63, 1'b0);  tick(); check("add_max", uo_out, 8'h7E);
        apply(8'd0, 8'd0, 1'b0);    tick(); check("add_zero", uo_out, 8'h00);
        apply(8'd21, 8'd42, 1'b0);  tick(); check("add_alt", uo_out, 8'h3F);
        ena = 1'b0;
        apply(8'd1, 8'd191, 1'b0);  tick(); check("add_ripple", uo_out, 8'h41);

        for (int ch = 0; ch < 4; ch++) begin
            bitv = 8'(1 << ch);
            qb   = bitv - 8'd1;
            apply(8'h40, bitv, 1'b0);        tick(); check("latch_d0_en1", uo_out, qb);
            apply(8'h40, 8'h00, 1'b0);       tick(); check("latch_hold0", uo_out, qb);
            apply(8'h40 | bitv, 8'h00, 1'b0); tick(); check("latch_d1_en0", uo_out, qb);
            apply(8'h40 | bitv, bitv, 1'b0); tick(); check("latch_d1_en1", uo_out, qb | bitv);
            apply(8'h40, 8'h00, 1'b0);       tick(); check("latch_hold1", uo_out, qb | bitv);
        end

        apply(8'h05, 8'h0F, 1'b0); tick(); check("iso_sum", uo_out, 8'h14);
        tick();
        apply(8'h40, 8'h00, 1'b0); tick(); check("iso_back", uo_out, 8'h0F);

        apply(8'h4F, 8'h0F, 1'b1); tick(); check("rst_override", uo_out, 8'h00);
        apply(8'h4A, 8'h0F, 1'b0); tick(); check("multi_write", uo_out, 8'h0A);
        apply(8'h45, 8'h03, 1'b0); tick(); check("partial_write", uo_out, 8'h09);
        apply(8'h40, 8'h00, 1'b0); tick(); check("final_hold", uo_out, 8'h09);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
